// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encodings, default bit period, data width.
// The PARITY state encoding exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 5202;
    localparam int DATA_W               = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out signal bundle of the UART transmitter.
// Handshake: TxStart is a request honoured only while the transmitter is idle (TxBusy low); no queueing.
interface uart_tx_if;
    import uart_tx_pkg::*;

    logic              TxStart;
    logic [DATA_W-1:0] TxData;
    logic              TxSerial;
    logic              TxBusy;
    logic              TxDone;

    modport master (
        output TxStart,
        output TxData,
        input  TxSerial,
        input  TxBusy,
        input  TxDone
    );

    modport slave (
        input  TxStart,
        input  TxData,
        output TxSerial,
        output TxBusy,
        output TxDone
    );
endinterface

// File: rtl/tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last count with Tick.
// Held at zero while Enable is low, so every frame starts on a fresh bit period.
module tx_baud_tick
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic SystemClock,
    input  logic ResetTimer,
    input  logic Enable,
    output logic Tick
);
    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (!Enable || (count_q == LAST)) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge SystemClock or negedge ResetTimer) begin
        if (!ResetTimer) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Tick = Enable && (count_q == LAST);
endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 frames LSB first; define UART_TX_PARITY_EN for 8E1 (even parity bit after data).
// TxSerial and TxBusy are registered; TxDone is decoded from registered state and the bit-period tick.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       SystemClock,
    input  logic       ResetTimer,
    uart_tx_if.slave   bus,
    output tx_state_e  state_dbg_o
);
    tx_state_e         state_q;
    logic [DATA_W-1:0] shift_q;
    logic [2:0]        idx_q;
    logic              serial_q;
    logic              busy_q;
`ifdef UART_TX_PARITY_EN
    logic              parity_q;
`endif
    logic              tick;
    logic              tick_en;

    assign tick_en = (state_q != ST_IDLE);

    tx_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .SystemClock (SystemClock),
        .ResetTimer  (ResetTimer),
        .Enable      (tick_en),
        .Tick        (tick)
    );

    // Line value is registered one state ahead: it changes on the edge that enters the next bit.
    always_ff @(posedge SystemClock or negedge ResetTimer) begin
        if (!ResetTimer) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.TxStart) begin
                        state_q  <= ST_START;
                        shift_q  <= bus.TxData;
                        idx_q    <= '0;
                        serial_q <= 1'b0;
                        busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^bus.TxData;
`endif
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state_q  <= ST_DATA;
                        serial_q <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        // idx wraps 7 -> 0, leaving it cleared for the next frame
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q  <= ST_PARITY;
                            serial_q <= parity_q;
`else
                            state_q  <= ST_STOP;
                            serial_q <= 1'b1;
`endif
                        end else begin
                            serial_q <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        state_q  <= ST_STOP;
                        serial_q <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    serial_q <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.TxSerial = serial_q;
    assign bus.TxBusy   = busy_q;
    assign bus.TxDone   = (state_q == ST_STOP) && tick;
    assign state_dbg_o  = state_q;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at CLKS_PER_BIT=4: drivers push expected bytes, a line-level receiver monitor
// decodes every frame from TxSerial samples and checks it against the queue (UART_TX_PARITY_EN aware).
module tb_uart_tx;
    import uart_tx_pkg::*;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * C;

    logic      clk;
    logic      rst_n;
    tx_state_e state_dbg;
    uart_tx_if bus ();

    uart_tx #(.CLKS_PER_BIT(C)) dut (
        .SystemClock (clk),
        .ResetTimer  (rst_n),
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_sent  = 0;
    int          n_abort = 0;
    int          n_done  = 0;
    int          cyc     = 0;
    int          done_cyc[$];
    logic [7:0]  exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.TxDone === 1'b1) begin
        n_done++;
        done_cyc.push_back(cyc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic send_now(input logic [7:0] d);
        bus.TxStart = 1'b1;
        bus.TxData  = d;
        @(posedge clk);
        exp_q.push_back(d);
        n_sent++;
        #1 bus.TxStart = 1'b0;
        @(negedge clk);
        chk("start_latency_serial", bus.TxSerial, 0);
        chk("start_latency_busy", bus.TxBusy, 1);
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        send_now(d);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.TxBusy === 1'b0) break;
        end
        if (k == 200) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.TxDone === 1'b1) break;
        end
        if (k == 200) chk("wait_done_timeout", 1, 0);
    endtask

    // scoreboard monitor: behaves like a UART receiver sampling every cycle
    logic ser_s  [FRAME_CYC];
    logic busy_s [FRAME_CYC];
    logic done_s [FRAME_CYC];
    logic bitv   [FRAME_BITS];

    initial begin : monitor
        logic       aborted;
        logic       hold_ok;
        logic       busy_ok;
        logic [7:0] rx;
        logic [7:0] ex;
        int         nd;
        int         got;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1 || bus.TxSerial !== 1'b0) continue;
            aborted = 1'b0;
            got = 0;
            for (int k = 0; k < FRAME_CYC; k++) begin
                if (k > 0) @(negedge clk);
                if (rst_n !== 1'b1) begin
                    aborted = 1'b1;
                    break;
                end
                ser_s[k]  = bus.TxSerial;
                busy_s[k] = bus.TxBusy;
                done_s[k] = bus.TxDone;
                got++;
            end
            nd = 0;
            for (int k = 0; k < got; k++) if (done_s[k] === 1'b1) nd++;
            if (aborted) begin
                chk("abort_no_done", nd, 0);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                continue;
            end
            hold_ok = 1'b1;
            for (int b = 0; b < FRAME_BITS; b++) begin
                bitv[b] = ser_s[b*C];
                for (int s = 1; s < C; s++) if (ser_s[b*C+s] !== bitv[b]) hold_ok = 1'b0;
            end
            busy_ok = 1'b1;
            for (int k = 0; k < FRAME_CYC; k++) if (busy_s[k] !== 1'b1) busy_ok = 1'b0;
            for (int i = 0; i < 8; i++) rx[i] = bitv[i+1];
            chk("bit_hold", hold_ok, 1);
            chk("start_bit", bitv[0], 0);
            chk("stop_bit", bitv[FRAME_BITS-1], 1);
            chk("busy_whole_frame", busy_ok, 1);
            chk("done_count_in_frame", nd, 1);
            chk("done_last_cycle", done_s[FRAME_CYC-1], 1);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame: got %0h expected none", rx);
            end else begin
                ex = exp_q.pop_front();
                chk("frame_data", rx, ex);
`ifdef UART_TX_PARITY_EN
                chk("parity_bit", bitv[8+1], ^ex);
`endif
            end
            @(negedge clk);
            chk("post_frame_serial", bus.TxSerial, 1);
            chk("post_frame_busy", bus.TxBusy, 0);
            chk("post_frame_done", bus.TxDone, 0);
        end
    end

    initial begin : stimulus
        int k;
        logic [7:0] d;
        rst_n       = 1'b0;
        bus.TxStart = 1'b0;
        bus.TxData  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_serial", bus.TxSerial, 1);
        chk("reset_busy", bus.TxBusy, 0);
        chk("reset_done", bus.TxDone, 0);
        chk("reset_state", state_dbg, ST_IDLE);

        // single byte accepted on the first edge after reset release
        @(negedge clk);
        rst_n = 1'b1;
        send_now(8'hA5);
        wait_idle();

        // TxStart while busy and during the TxDone cycle is ignored
        send(8'h3C);
        repeat (10) @(negedge clk);
        bus.TxStart = 1'b1;
        bus.TxData  = 8'hFF;
        @(posedge clk);
        #1 bus.TxStart = 1'b0;
        wait_done();
        bus.TxStart = 1'b1;
        bus.TxData  = 8'hFF;
        @(posedge clk);
        #1 bus.TxStart = 1'b0;
        repeat (4) @(negedge clk);
        chk("no_queued_start", bus.TxBusy, 0);

        // back-to-back frames with TxStart held high
        @(negedge clk);
        bus.TxStart = 1'b1;
        bus.TxData  = 8'h00;
        @(posedge clk);
        exp_q.push_back(8'h00);
        n_sent++;
        @(negedge clk);
        bus.TxData = 8'hFF;
        wait_done();
        @(posedge clk);
        @(posedge clk);
        exp_q.push_back(8'hFF);
        n_sent++;
        #1 bus.TxStart = 1'b0;
        wait_idle();
        if (done_cyc.size() >= 2)
            chk("b2b_done_gap", done_cyc[$] - done_cyc[$-1], FRAME_CYC + 1);
        else
            chk("b2b_done_seen", done_cyc.size(), 2);

        // mid-frame reset at cycle 17
        send(8'h55);
        repeat (16) @(posedge clk);
        #2 rst_n = 1'b0;
        n_abort++;
        #1;
        chk("midreset_serial", bus.TxSerial, 1);
        chk("midreset_busy", bus.TxBusy, 0);
        chk("midreset_done", bus.TxDone, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("after_reset_idle_high", {bus.TxSerial, bus.TxBusy}, 2'b10);
        end
        send(8'h81);
        wait_idle();

        // TxData churns every cycle of the frame
        send(8'h0F);
        for (int i = 0; i < FRAME_CYC; i++) begin
            bus.TxData = 8'($urandom);
            @(negedge clk);
        end
        wait_idle();

        // random bytes with random gaps, then the parity reference bytes
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom_range(0, 255));
            send(d);
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        send(8'h07);
        wait_idle();
        send(8'h03);
        wait_idle();

        for (k = 0; k < 200; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("total_done_pulses", n_done, n_sent - n_abort);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
